enoc_node_interface: RTL and testbench

- Node-side endpoint of the ENoC valid/enable link; one instance per node, attached to one network port index.
- Buffers packets from the local traffic source in a TX FIFO and presents them to the network.
- Accepts packets from the network into an RX FIFO and presents them to the local traffic sink.
- Keeps wrap-around TX/RX packet counters for the statistics logic.

---
 rtl/enoc_node_interface.sv | 151 +++++++++++++++
 tb/tb_enoc_node_interface.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/enoc_node_interface.sv
// ENoC node endpoint: TX/RX packet FIFOs between the local source/sink and one
// network port, plus wrap-around transfer counters for statistics.

module enoc_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  // push/pop are already qualified by the caller with !full / !empty
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once occ_q is 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (occ_q == '0);
  assign full  = (occ_q == (AW+1)'(DEPTH));
endmodule

module enoc_node_interface #(
  parameter int PACKET_WIDTH = 64,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] i_src_data,
  input  logic                    i_src_val,
  output logic                    o_src_en,
  output logic [PACKET_WIDTH-1:0] o_net_data,
  output logic                    o_net_data_val,
  input  logic                    i_net_en,
  input  logic [PACKET_WIDTH-1:0] i_net_data,
  input  logic                    i_net_data_val,
  output logic                    o_net_en,
  output logic [PACKET_WIDTH-1:0] o_snk_data,
  output logic                    o_snk_val,
  input  logic                    i_snk_en,
  output logic [COUNT_WIDTH-1:0]  o_tx_count,
  output logic [COUNT_WIDTH-1:0]  o_rx_count
);
  logic rdy_q, rdy_d;
  logic tx_push, tx_pop, tx_empty, tx_full;
  logic rx_push, rx_pop, rx_empty, rx_full;
  logic [COUNT_WIDTH-1:0] tx_count_q, tx_count_d;
  logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;

  // Enables come only from registered state, so there is no comb path from the network side.
  assign o_src_en       = rdy_q && !tx_full;
  assign o_net_en       = rdy_q && !rx_full;
  assign o_net_data_val = !tx_empty;
  assign o_snk_val      = !rx_empty;

  assign tx_push = i_src_val && o_src_en;
  assign tx_pop  = o_net_data_val && i_net_en;
  assign rx_push = i_net_data_val && o_net_en;
  assign rx_pop  = o_snk_val && i_snk_en;

  enoc_fifo #(.W(PACKET_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (tx_pop),
    .wdata   (i_src_data),
    .rdata   (o_net_data),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  enoc_fifo #(.W(PACKET_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (i_net_data),
    .rdata   (o_snk_data),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  always_comb begin
    rdy_d      = 1'b1;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    if (tx_pop)  tx_count_d = tx_count_q + COUNT_WIDTH'(1);
    if (rx_push) rx_count_d = rx_count_q + COUNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b0;
      tx_count_q <= '0;
      rx_count_q <= '0;
    end else begin
      rdy_q      <= rdy_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign o_tx_count = tx_count_q;
  assign o_rx_count = rx_count_q;
endmodule

// File: tb/tb_enoc_node_interface.sv
// Directed bench for enoc_node_interface: table of per-cycle vectors plus
// hand-written reset, streaming and counter-wrap sequences.

module tb_enoc_node_interface;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] i_src_data, o_net_data, i_net_data, o_snk_data;
  logic        i_src_val, o_src_en, o_net_data_val, i_net_en;
  logic        i_net_data_val, o_net_en, o_snk_val, i_snk_en;
  logic [15:0] o_tx_count, o_rx_count;

  logic [63:0] w_src_data, w_net_data_o, w_net_data_i, w_snk_data;
  logic        w_src_val, w_src_en, w_net_val_o, w_net_en_i;
  logic        w_net_val_i, w_net_en_o, w_snk_val, w_snk_en;
  logic [3:0]  w_tx_count, w_rx_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enoc_node_interface dut (
    .clk(clk), .reset_n(reset_n),
    .i_src_data(i_src_data), .i_src_val(i_src_val), .o_src_en(o_src_en),
    .o_net_data(o_net_data), .o_net_data_val(o_net_data_val), .i_net_en(i_net_en),
    .i_net_data(i_net_data), .i_net_data_val(i_net_data_val), .o_net_en(o_net_en),
    .o_snk_data(o_snk_data), .o_snk_val(o_snk_val), .i_snk_en(i_snk_en),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count)
  );

  enoc_node_interface #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .i_src_data(w_src_data), .i_src_val(w_src_val), .o_src_en(w_src_en),
    .o_net_data(w_net_data_o), .o_net_data_val(w_net_val_o), .i_net_en(w_net_en_i),
    .i_net_data(w_net_data_i), .i_net_data_val(w_net_val_i), .o_net_en(w_net_en_o),
    .o_snk_data(w_snk_data), .o_snk_val(w_snk_val), .i_snk_en(w_snk_en),
    .o_tx_count(w_tx_count), .o_rx_count(w_rx_count)
  );

  typedef struct {
    logic        src_val;
    logic [63:0] src_data;
    logic        net_en;
    logic        net_val;
    logic [63:0] net_data;
    logic        snk_en;
    logic        e_src_en;
    logic        e_net_val;
    logic [63:0] e_net_data;
    logic        e_net_en;
    logic        e_snk_val;
    logic [63:0] e_snk_data;
    logic [15:0] e_tx;
    logic [15:0] e_rx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_src_val = 0; i_src_data = '0; i_net_en = 0;
    i_net_data_val = 0; i_net_data = '0; i_snk_en = 0;
  endtask

  initial begin
    int delivered;
    logic [63:0] exp_pkt;

    reset_n = 0;
    idle_inputs();
    w_src_val = 0; w_src_data = '0; w_net_en_i = 0;
    w_net_val_i = 0; w_net_data_i = '0; w_snk_en = 1;

    // TX backpressure then drain
    vecs.push_back('{1, 64'hA1, 0, 0, 0, 0,  1, 1, 64'hA1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 64'hA2, 0, 0, 0, 0,  1, 1, 64'hA1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 64'hA3, 0, 0, 0, 0,  1, 1, 64'hA1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 64'hA4, 0, 0, 0, 0,  0, 1, 64'hA1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 64'hA5, 0, 0, 0, 0,  0, 1, 64'hA1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 64'hA5, 1, 0, 0, 0,  1, 1, 64'hA2, 1, 0, 0, 1, 0});
    vecs.push_back('{1, 64'hA5, 1, 0, 0, 0,  1, 1, 64'hA3, 1, 0, 0, 2, 0});
    vecs.push_back('{0, 64'h0,  1, 0, 0, 0,  1, 1, 64'hA4, 1, 0, 0, 3, 0});
    vecs.push_back('{0, 64'h0,  1, 0, 0, 0,  1, 1, 64'hA5, 1, 0, 0, 4, 0});
    vecs.push_back('{0, 64'h0,  1, 0, 0, 0,  1, 0, 64'h0,  1, 0, 0, 5, 0});
    vecs.push_back('{0, 64'hDEAD, 1, 0, 0, 0, 1, 0, 64'h0, 1, 0, 0, 5, 0});
    // RX fill, single sink pulse, refill, drain
    vecs.push_back('{0, 0, 0, 1, 64'hB0, 0,  1, 0, 0, 1, 1, 64'hB0, 5, 1});
    vecs.push_back('{0, 0, 0, 1, 64'hB1, 0,  1, 0, 0, 1, 1, 64'hB0, 5, 2});
    vecs.push_back('{0, 0, 0, 1, 64'hB2, 0,  1, 0, 0, 1, 1, 64'hB0, 5, 3});
    vecs.push_back('{0, 0, 0, 1, 64'hB3, 0,  1, 0, 0, 0, 1, 64'hB0, 5, 4});
    vecs.push_back('{0, 0, 0, 1, 64'hB4, 0,  1, 0, 0, 0, 1, 64'hB0, 5, 4});
    vecs.push_back('{0, 0, 0, 1, 64'hB4, 1,  1, 0, 0, 1, 1, 64'hB1, 5, 4});
    vecs.push_back('{0, 0, 0, 1, 64'hB4, 0,  1, 0, 0, 0, 1, 64'hB1, 5, 5});
    vecs.push_back('{0, 0, 0, 0, 64'h0,  1,  1, 0, 0, 1, 1, 64'hB2, 5, 5});
    vecs.push_back('{0, 0, 0, 0, 64'h0,  1,  1, 0, 0, 1, 1, 64'hB3, 5, 5});
    vecs.push_back('{0, 0, 0, 0, 64'h0,  1,  1, 0, 0, 1, 1, 64'hB4, 5, 5});
    vecs.push_back('{0, 0, 0, 0, 64'h0,  1,  1, 0, 0, 1, 0, 64'h0,  5, 5});

    // Reset for 3 cycles, enables rise exactly one edge after release
    repeat (3) tick();
    chk("rst_src_en", o_src_en, 0);
    chk("rst_net_en", o_net_en, 0);
    chk("rst_net_val", o_net_data_val, 0);
    chk("rst_snk_val", o_snk_val, 0);
    reset_n = 1;
    #1;
    chk("rel_src_en_pre_edge", o_src_en, 0);
    chk("rel_net_en_pre_edge", o_net_en, 0);
    tick();
    chk("rel_src_en", o_src_en, 1);
    chk("rel_net_en", o_net_en, 1);
    chk("rel_net_val", o_net_data_val, 0);
    chk("rel_snk_val", o_snk_val, 0);
    chk("rel_tx_count", o_tx_count, 0);
    chk("rel_rx_count", o_rx_count, 0);

    foreach (vecs[i]) begin
      i_src_val      = vecs[i].src_val;
      i_src_data     = vecs[i].src_data;
      i_net_en       = vecs[i].net_en;
      i_net_data_val = vecs[i].net_val;
      i_net_data     = vecs[i].net_data;
      i_snk_en       = vecs[i].snk_en;
      tick();
      chk($sformatf("v%0d_src_en", i), o_src_en, vecs[i].e_src_en);
      chk($sformatf("v%0d_net_val", i), o_net_data_val, vecs[i].e_net_val);
      if (vecs[i].e_net_val) chk($sformatf("v%0d_net_data", i), o_net_data, vecs[i].e_net_data);
      chk($sformatf("v%0d_net_en", i), o_net_en, vecs[i].e_net_en);
      chk($sformatf("v%0d_snk_val", i), o_snk_val, vecs[i].e_snk_val);
      if (vecs[i].e_snk_val) chk($sformatf("v%0d_snk_data", i), o_snk_data, vecs[i].e_snk_data);
      chk($sformatf("v%0d_tx_count", i), o_tx_count, vecs[i].e_tx);
      chk($sformatf("v%0d_rx_count", i), o_rx_count, vecs[i].e_rx);
    end

    // Async reset with 3 packets in each FIFO
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      i_src_val = 1; i_src_data = 64'hC0 + 64'(k);
      i_net_data_val = 1; i_net_data = 64'hD0 + 64'(k);
      tick();
    end
    idle_inputs();
    chk("pre_arst_net_val", o_net_data_val, 1);
    chk("pre_arst_snk_val", o_snk_val, 1);
    #2;
    reset_n = 0;
    #1;
    chk("arst_net_val", o_net_data_val, 0);
    chk("arst_snk_val", o_snk_val, 0);
    chk("arst_src_en", o_src_en, 0);
    chk("arst_net_en", o_net_en, 0);
    chk("arst_tx_count", o_tx_count, 0);
    chk("arst_rx_count", o_rx_count, 0);
    tick();
    tick();
    reset_n = 1;
    i_net_en = 1; i_snk_en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_arst%0d_net_val", k), o_net_data_val, 0);
      chk($sformatf("post_arst%0d_snk_val", k), o_snk_val, 0);
      chk($sformatf("post_arst%0d_tx_count", k), o_tx_count, 0);
      chk($sformatf("post_arst%0d_rx_count", k), o_rx_count, 0);
    end

    // Full-rate streaming for 100 cycles
    delivered = 0;
    exp_pkt = 64'h1000;
    i_net_en = 1; i_snk_en = 0;
    for (int k = 0; k < 100; k++) begin
      i_src_val = 1;
      i_src_data = 64'h1000 + 64'(k);
      chk($sformatf("stream%0d_src_en", k), o_src_en, 1);
      if (o_net_data_val) begin
        chk($sformatf("stream_pkt%0d", delivered), o_net_data, exp_pkt);
        exp_pkt = exp_pkt + 64'd1;
        delivered++;
      end
      tick();
    end
    i_src_val = 0; i_net_en = 0;
    chk("stream_delivered", 64'(delivered), 64'd99);
    chk("stream_tx_count", o_tx_count, 16'd99);

    // Counter wrap on a 4-bit instance: 17 RX transfers
    chk("wrap_start", w_rx_count, 4'h0);
    for (int k = 1; k <= 17; k++) begin
      w_net_val_i = 1;
      w_net_data_i = 64'(k);
      tick();
      if (k == 15) chk("wrap_15", w_rx_count, 4'hF);
      if (k == 16) chk("wrap_16", w_rx_count, 4'h0);
      if (k == 17) chk("wrap_17", w_rx_count, 4'h1);
    end
    w_net_val_i = 0;
    chk("wrap_net_en", w_net_en_o, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
